mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-client arbiter that shares the single `mem_wrap` port between two cache instances (e.g. instruction and data caches). Each client issues 13-bit line-refill reads (32-bit line returned) and 8-bit write-through writes, using the same request signals the cache already drives toward memory. The arbiter serialises these requests onto one memory port with round-robin fairness between clients, at most one read outstanding, and a read-response watchdog.

## Interface
- `RD_TIMEOUT`, 64: maximum number of RD_WAIT cycles allowed without `mem_rvalid`; must be ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `c0_rreq`  in  1  client 0 read request; held high until `c0_rvalid`.
- `c0_raddr`  in  13  client 0 read address; stable while `c0_rreq` is high.
- `c0_rdata`  out  32  client 0 read data; valid while `c0_rvalid` is high, holds its value otherwise.
- `c0_rvalid`  out  1  one-cycle read-done pulse to client 0.
- `c0_wreq`  in  1  client 0 write request; held high until `c0_wack`.
- `c0_waddr`  in  13  client 0 write address.
- `c0_wdata`  in  8  client 0 write data.
- `c0_wack`  out  1  one-cycle write-accepted pulse to client 0.
- `c1_*`: same set as `c0_*`, for client 1.
- `mem_rreq`  out  1  one-cycle read strobe to memory.
- `mem_raddr`  out  13  read address; held for the whole read.
- `mem_rdata`  in  32  memory line data.
- `mem_rvalid`  in  1  memory read-done pulse.
- `mem_wreq`  out  1  one-cycle write strobe to memory.
- `mem_waddr`  out  13  write address.
- `mem_wdata`  out  8  write data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  sticky flag, set on a watchdog expiry; cleared only by reset.

## Operation
- FSM states: IDLE, WRITE, RD_WAIT, RD_RESP.
- Registered `last`: the client granted most recently. Reset value is 1, so client 0 wins the first tie.
- **IDLE – client selection:**
  - If only one client has any request (`rreq` or `wreq`), select it.
  - If both have requests, select the client ≠ `last`.
- **IDLE – request selection within the chosen client:** `wreq` has priority over `rreq`, so write-through reaches memory before a refill.
- **Write grant** → WRITE. In WRITE:
  - `mem_wreq` = 1.
  - `mem_waddr`/`mem_wdata` carry the latched client values.
  - The chosen client's `wack` = 1.
  - `last` is updated.
  - Next state is IDLE.
- **Read grant** → RD_WAIT:
  - `mem_raddr` is latched from the client.
  - `mem_rreq` = 1 in the first RD_WAIT cycle only.
  - `last` is updated.
  - The watchdog counter is cleared to 0 on entry and increments each RD_WAIT cycle.
- **RD_WAIT exits:**
  - On `mem_rvalid`: latch `mem_rdata` into the selected client's `rdata` and go to RD_RESP.
  - When the counter reaches `RD_TIMEOUT - 1` with no `mem_rvalid`: set `timeout_err` and return to IDLE. The client still holds `rreq`, so the read is re-arbitrated as a retry.
  - If `mem_rvalid` and expiry occur in the same cycle, `mem_rvalid` wins and no error is raised.
- **RD_RESP:** the selected client's `rvalid` = 1 for one cycle, then IDLE.
- **Ignored inputs:**
  - `mem_rvalid` outside RD_WAIT is ignored. A late response after a timeout is dropped.
  - Requests that arrive in non-IDLE states wait in their held state; nothing is queued internally.
- The counter is sized `$clog2(RD_TIMEOUT+1)` bits and never wraps; it is cleared on RD_WAIT entry.
- **Reset values:** all outputs are 0 (including both `rdata` registers), state = IDLE, counter = 0, `last` = 1. Reset asserted mid-read abandons the read, and any later `mem_rvalid` is ignored.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- **Write:** request sampled in IDLE at cycle t → `mem_wreq` and `wack` at t+1 → IDLE at t+2. Peak rate is one write per 2 cycles.
- **Read:** request sampled at t → `mem_rreq` at t+1.
  - If `mem_rvalid` arrives at t+1+k (k ≥ 0), the client's `rvalid` is high at t+2+k.
  - The arbiter is back in IDLE at t+3+k.
- **Client obligation:** drop `wreq`/`rreq` on the edge that samples `wack`/`rvalid`. Otherwise the request is serviced again.
- `busy` rises the cycle after a grant decision and falls on the cycle the FSM returns to IDLE.

## Test plan
- **Reset:** hold `reset` = 0 with random inputs → every output 0. Release → first tie grants client 0.
- **Single write:** `c0_wreq`, `c0_waddr` = 0x0A5, `c0_wdata` = 0xFF at t → at t+1 `mem_wreq` = 1, `mem_waddr` = 0x0A5, `mem_wdata` = 0xFF, `c0_wack` = 1, each for exactly one cycle.
- **Single read:** `c1_rreq`, `c1_raddr` = 0x1F00; memory returns 0xDEADBEEF 3 cycles after `mem_rreq` → `c1_rvalid` pulses once with `c1_rdata` = 0xDEADBEEF. `c0_rvalid` stays 0, and `c0_rdata` keeps its prior value.
- **Contention:**
  - Both clients hold `rreq` continuously → grants alternate c0, c1, c0, c1.
  - c0 holding both `wreq` and `rreq` → write issued before the read.
- **Timeout:** `RD_TIMEOUT` = 8, memory silent → `timeout_err` = 1 after 8 RD_WAIT cycles, then `mem_rreq` is reissued. Memory then responds 0x12345678 → delivered to the client, and `timeout_err` stays 1.
- **Reset mid-read:** assert reset in RD_WAIT, release, then pulse `mem_rvalid` → no client `rvalid`, `rdata` registers remain 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter sharing one memory port: write-through writes
// and line-refill reads, one read outstanding, with a read-response watchdog.
module mem_arbiter #(
    parameter int RD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_rreq,
    input  logic [12:0] c0_raddr,
    output logic [31:0] c0_rdata,
    output logic        c0_rvalid,
    input  logic        c0_wreq,
    input  logic [12:0] c0_waddr,
    input  logic [7:0]  c0_wdata,
    output logic        c0_wack,
    input  logic        c1_rreq,
    input  logic [12:0] c1_raddr,
    output logic [31:0] c1_rdata,
    output logic        c1_rvalid,
    input  logic        c1_wreq,
    input  logic [12:0] c1_waddr,
    input  logic [7:0]  c1_wdata,
    output logic        c1_wack,
    output logic        mem_rreq,
    output logic [12:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wreq,
    output logic [12:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_RESP} state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_sel;
    logic [CW-1:0] r_cnt;

    logic          w_req0;
    logic          w_req1;
    logic          w_pick1;
    logic          w_wr;
    logic [12:0]   w_waddr;
    logic [7:0]    w_wdata;
    logic [12:0]   w_raddr;

    // On a tie the client that was not granted last wins; writes beat reads.
    assign w_req0  = c0_rreq | c0_wreq;
    assign w_req1  = c1_rreq | c1_wreq;
    assign w_pick1 = w_req1 & (~w_req0 | ~r_last);
    assign w_wr    = w_pick1 ? c1_wreq  : c0_wreq;
    assign w_waddr = w_pick1 ? c1_waddr : c0_waddr;
    assign w_wdata = w_pick1 ? c1_wdata : c0_wdata;
    assign w_raddr = w_pick1 ? c1_raddr : c0_raddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            c0_rdata    <= '0;
            c0_rvalid   <= 1'b0;
            c0_wack     <= 1'b0;
            c1_rdata    <= '0;
            c1_rvalid   <= 1'b0;
            c1_wack     <= 1'b0;
            mem_rreq    <= 1'b0;
            mem_raddr   <= '0;
            mem_wreq    <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mem_rreq  <= 1'b0;
            mem_wreq  <= 1'b0;
            c0_wack   <= 1'b0;
            c1_wack   <= 1'b0;
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_sel  <= w_pick1;
                        r_last <= w_pick1;
                        busy   <= 1'b1;
                        if (w_wr) begin
                            r_state   <= WRITE;
                            mem_wreq  <= 1'b1;
                            mem_waddr <= w_waddr;
                            mem_wdata <= w_wdata;
                            c0_wack   <= ~w_pick1;
                            c1_wack   <= w_pick1;
                        end else begin
                            r_state   <= RD_WAIT;
                            mem_rreq  <= 1'b1;
                            mem_raddr <= w_raddr;
                            r_cnt     <= '0;
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                RD_WAIT: begin
                    // A response in the expiry cycle still counts as a success.
                    if (mem_rvalid) begin
                        r_state <= RD_RESP;
                        if (r_sel) begin
                            c1_rdata  <= mem_rdata;
                            c1_rvalid <= 1'b1;
                        end else begin
                            c0_rdata  <= mem_rdata;
                            c0_rvalid <= 1'b1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RD_RESP: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven write arbitration plus
// hand-written read, contention, timeout and reset sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        c0_rreq, c0_wreq, c1_rreq, c1_wreq;
    logic [12:0] c0_raddr, c0_waddr, c1_raddr, c1_waddr;
    logic [7:0]  c0_wdata, c1_wdata;
    logic [31:0] c0_rdata, c1_rdata;
    logic        c0_rvalid, c1_rvalid, c0_wack, c1_wack;
    logic        mem_rreq, mem_wreq, mem_rvalid;
    logic [12:0] mem_raddr, mem_waddr;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy, timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(.RD_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .c0_rreq(c0_rreq), .c0_raddr(c0_raddr), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
        .c0_wreq(c0_wreq), .c0_waddr(c0_waddr), .c0_wdata(c0_wdata), .c0_wack(c0_wack),
        .c1_rreq(c1_rreq), .c1_raddr(c1_raddr), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
        .c1_wreq(c1_wreq), .c1_waddr(c1_waddr), .c1_wdata(c1_wdata), .c1_wack(c1_wack),
        .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wreq(mem_wreq), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        c0w;
        logic        c1w;
        logic [12:0] c0a;
        logic [12:0] c1a;
        logic [7:0]  c0d;
        logic [7:0]  c1d;
        logic        e_wreq;
        logic [12:0] e_addr;
        logic [7:0]  e_data;
        logic        e_ack0;
        logic        e_ack1;
        logic        e_busy;
    } wvec_t;

    wvec_t tbl [10];
    logic  exp_order [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ctrl_vec();
        return {22'd0, c0_rvalid, c1_rvalid, c0_wack, c1_wack, mem_rreq, mem_raddr,
                mem_wreq, mem_waddr, mem_wdata, busy, timeout_err};
    endfunction

    task automatic do_read(input int cl, input logic [12:0] a, input logic [31:0] d, input int k);
        if (cl == 0) begin c0_rreq = 1'b1; c0_raddr = a; end
        else begin c1_rreq = 1'b1; c1_raddr = a; end
        step();
        chk("rd_mem_rreq", mem_rreq, 1);
        chk("rd_raddr", mem_raddr, a);
        chk("rd_busy", busy, 1);
        for (int i = 0; i < k; i++) begin
            step();
            chk("rd_wait_rreq", mem_rreq, 0);
            chk("rd_wait_busy", busy, 1);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("rd_rvalid", (cl == 0) ? c0_rvalid : c1_rvalid, 1);
        chk("rd_other_rvalid", (cl == 0) ? c1_rvalid : c0_rvalid, 0);
        chk("rd_rdata", (cl == 0) ? c0_rdata : c1_rdata, d);
        chk("rd_no_timeout", timeout_err, 0);
        c0_rreq = 1'b0;
        c1_rreq = 1'b0;
        step();
        chk("rd_rvalid_pulse", (cl == 0) ? c0_rvalid : c1_rvalid, 0);
        chk("rd_idle_busy", busy, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 13'h0A5, 13'h111, 8'hFF, 8'h22, 1'b1, 13'h0A5, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 13'h0A5, 13'h111, 8'hFF, 8'h22, 1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 13'h0A5, 13'h111, 8'hFF, 8'h22, 1'b1, 13'h111, 8'h22, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 13'h0A5, 13'h111, 8'hFF, 8'h22, 1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 13'h003, 13'h004, 8'h33, 8'h44, 1'b1, 13'h003, 8'h33, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 13'h003, 13'h004, 8'h33, 8'h44, 1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 13'h005, 13'h004, 8'h55, 8'h44, 1'b1, 13'h004, 8'h44, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 13'h005, 13'h004, 8'h55, 8'h44, 1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 13'h005, 13'h004, 8'h55, 8'h44, 1'b1, 13'h005, 8'h55, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 13'h005, 13'h004, 8'h55, 8'h44, 1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0};
        exp_order[0] = 1'b0;
        exp_order[1] = 1'b1;
        exp_order[2] = 1'b0;
        exp_order[3] = 1'b1;

        // Reset held with random inputs: every output stays zero.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c0_rreq = 1'($urandom); c0_wreq = 1'($urandom);
            c1_rreq = 1'($urandom); c1_wreq = 1'($urandom);
            c0_raddr = 13'($urandom); c0_waddr = 13'($urandom); c0_wdata = 8'($urandom);
            c1_raddr = 13'($urandom); c1_waddr = 13'($urandom); c1_wdata = 8'($urandom);
            mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            step();
            chk("reset_ctrl", ctrl_vec(), 64'h0);
            chk("reset_c0_rdata", c0_rdata, 0);
            chk("reset_c1_rdata", c1_rdata, 0);
        end
        c0_rreq = 1'b0; c0_wreq = 1'b0; c1_rreq = 1'b0; c1_wreq = 1'b0;
        c0_raddr = '0; c0_waddr = '0; c0_wdata = '0;
        c1_raddr = '0; c1_waddr = '0; c1_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        reset = 1'b1;
        step();

        // Write arbitration table, starting with the first tie after reset.
        for (int i = 0; i < 10; i++) begin
            c0_wreq = tbl[i].c0w; c1_wreq = tbl[i].c1w;
            c0_waddr = tbl[i].c0a; c1_waddr = tbl[i].c1a;
            c0_wdata = tbl[i].c0d; c1_wdata = tbl[i].c1d;
            step();
            chk($sformatf("wr%0d_mem_wreq", i), mem_wreq, tbl[i].e_wreq);
            chk($sformatf("wr%0d_c0_wack", i), c0_wack, tbl[i].e_ack0);
            chk($sformatf("wr%0d_c1_wack", i), c1_wack, tbl[i].e_ack1);
            chk($sformatf("wr%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("wr%0d_mem_rreq", i), mem_rreq, 0);
            if (tbl[i].e_wreq) begin
                chk($sformatf("wr%0d_waddr", i), mem_waddr, tbl[i].e_addr);
                chk($sformatf("wr%0d_wdata", i), mem_wdata, tbl[i].e_data);
            end
        end

        // Single reads; the k=7 read lands exactly in the watchdog expiry cycle.
        do_read(0, 13'h0123, 32'hCAFEF00D, 0);
        do_read(1, 13'h1F00, 32'hDEADBEEF, 3);
        chk("c0_rdata_kept", c0_rdata, 32'hCAFEF00D);
        do_read(1, 13'h0321, 32'h0BADF00D, 7);
        chk("c0_rdata_kept2", c0_rdata, 32'hCAFEF00D);

        // Both clients hold rreq continuously: grants alternate c0, c1, c0, c1.
        c0_rreq = 1'b1; c0_raddr = 13'h0AAA;
        c1_rreq = 1'b1; c1_raddr = 13'h1BBB;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rr%0d_mem_rreq", i), mem_rreq, 1);
            chk($sformatf("rr%0d_raddr", i), mem_raddr, exp_order[i] ? 13'h1BBB : 13'h0AAA);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h1000_0000 + i;
            step();
            mem_rvalid = 1'b0;
            chk($sformatf("rr%0d_c0_rvalid", i), c0_rvalid, !exp_order[i]);
            chk($sformatf("rr%0d_c1_rvalid", i), c1_rvalid, exp_order[i]);
            chk($sformatf("rr%0d_rdata", i), exp_order[i] ? c1_rdata : c0_rdata, 32'h1000_0000 + i);
            if (i == 3) begin c0_rreq = 1'b0; c1_rreq = 1'b0; end
            step();
            chk($sformatf("rr%0d_idle", i), busy, 0);
        end

        // Client 0 holds both a write and a read: the write goes first.
        c0_wreq = 1'b1; c0_waddr = 13'h0777; c0_wdata = 8'h77;
        c0_rreq = 1'b1; c0_raddr = 13'h0888;
        step();
        chk("wfirst_mem_wreq", mem_wreq, 1);
        chk("wfirst_mem_rreq", mem_rreq, 0);
        chk("wfirst_waddr", mem_waddr, 13'h0777);
        chk("wfirst_wack", c0_wack, 1);
        c0_wreq = 1'b0;
        step();
        chk("wfirst_idle", busy, 0);
        step();
        chk("wfirst_then_rreq", mem_rreq, 1);
        chk("wfirst_then_raddr", mem_raddr, 13'h0888);
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_rvalid = 1'b0;
        chk("wfirst_rvalid", c0_rvalid, 1);
        chk("wfirst_rdata", c0_rdata, 32'hA5A5A5A5);
        c0_rreq = 1'b0;
        step();

        // Silent memory: watchdog expires after 8 RD_WAIT cycles, then retry.
        c1_rreq = 1'b1; c1_raddr = 13'h1234;
        step();
        chk("to_mem_rreq", mem_rreq, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("to_wait%0d_err", i), timeout_err, 0);
            chk($sformatf("to_wait%0d_busy", i), busy, 1);
        end
        step();
        chk("to_err_set", timeout_err, 1);
        chk("to_back_idle", busy, 0);
        chk("to_no_rvalid", c1_rvalid, 0);
        step();
        chk("to_retry_rreq", mem_rreq, 1);
        chk("to_retry_raddr", mem_raddr, 13'h1234);
        step();
        chk("to_retry_rreq_drop", mem_rreq, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        chk("to_retry_rvalid", c1_rvalid, 1);
        chk("to_retry_rdata", c1_rdata, 32'h12345678);
        chk("to_err_sticky", timeout_err, 1);
        c1_rreq = 1'b0;
        step();
        chk("to_err_sticky2", timeout_err, 1);
        chk("to_final_idle", busy, 0);

        // Reset in RD_WAIT abandons the read; a later response is ignored.
        c0_rreq = 1'b1; c0_raddr = 13'h0042;
        step();
        chk("rst_rd_rreq", mem_rreq, 1);
        step();
        reset = 1'b0;
        c0_rreq = 1'b0;
        #1;
        chk("rst_mid_ctrl", ctrl_vec(), 64'h0);
        chk("rst_mid_c0_rdata", c0_rdata, 0);
        chk("rst_mid_c1_rdata", c1_rdata, 0);
        step();
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        step();
        mem_rvalid = 1'b0;
        chk("rst_late_c0_rvalid", c0_rvalid, 0);
        chk("rst_late_c1_rvalid", c1_rvalid, 0);
        chk("rst_late_c0_rdata", c0_rdata, 0);
        chk("rst_late_c1_rdata", c1_rdata, 0);
        chk("rst_late_busy", busy, 0);
        step();
        chk("rst_late_ctrl", ctrl_vec(), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
